// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared constants and helpers for the parametrised serial pattern detector.
//   MODE_MEALY / MODE_MOORE : values for the MEALY parameter of seq_detect_param
//   OVL_ON / OVL_OFF        : values for the OVERLAP parameter
//   clog2(value)            : bits needed to encode 0..value-1, sizes 'fill'
// -----------------------------------------------------------------------------
package seq_detect_pkg;

  localparam bit MODE_MEALY = 1'b1;
  localparam bit MODE_MOORE = 1'b0;

  localparam bit OVL_ON  = 1'b1;
  localparam bit OVL_OFF = 1'b0;

  // Smallest width able to hold every value in 0..value-1. A fixed-bound loop
  // keeps this usable as a constant function in port declarations.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that stops at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous, active-low clear
//   inc   : count enable, one increment per cycle while high
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on each enabled cycle; once every bit is set the value is held so
  // a long run of matches never appears to restart from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial bit-pattern detector with a runtime-loadable N-bit pattern, optional
// overlapping matches, Mealy or registered (Moore-style) match output, an input
// valid qualifier and a saturating match counter.
//   clk       : rising-edge clock
//   reset     : synchronous, active-low
//   in_valid  : in_bit is consumed only when high
//   in_bit    : serial data, first-received bit lines up with pattern MSB
//   pat_load  : one-cycle strobe, loads pat_in and flushes the history
//   pat_in    : new pattern (MSB = first bit)
//   out       : one-cycle match pulse
//   match_cnt : saturating count of matches
//   fill      : number of valid history bits (0..N)
// -----------------------------------------------------------------------------
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int           N        = 4,
  parameter logic [N-1:0] PAT_INIT = 4'b1011,
  parameter bit           OVERLAP  = OVL_ON,
  parameter bit           MEALY    = MODE_MEALY,
  parameter int           CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_bit,
  input  logic                     pat_load,
  input  logic [N-1:0]             pat_in,
  output logic                     out,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [clog2(N+1)-1:0]    fill
);

  localparam int FILL_W = clog2(N + 1);

  // Only the newest N-1 history bits matter: together with the incoming bit
  // they form the full N-bit comparison window, so the oldest bit of the
  // window is never stored.
  logic [N-2:0]      r_hist;
  logic [N-1:0]      r_pattern;
  logic [FILL_W-1:0] r_fill;
  logic              r_out;

  logic              w_accept;
  logic [N-1:0]      w_window;
  logic              w_hit;

  // A bit is taken only outside reset and when no pattern load is happening
  // in the same cycle; a load always discards the simultaneous data bit.
  // A hit needs N-1 valid history bits plus the incoming bit to equal the
  // pattern. Gating with reset keeps the Mealy output low during reset.
  always_comb begin
    w_accept = reset & in_valid & ~pat_load;
    w_window = {r_hist, in_bit};
    w_hit    = w_accept
             & (r_fill >= FILL_W'(N - 1))
             & (w_window == r_pattern);
  end

  // History, fill level and pattern register. With overlap disabled a match
  // empties the fill count so the next match must be built from fresh bits;
  // the history still shifts but its contents are meaningless until refilled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= PAT_INIT;
    end else if (pat_load) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= pat_in;
    end else if (in_valid) begin
      r_hist <= w_window[N-2:0];
      if (w_hit && (OVERLAP == OVL_OFF)) begin
        r_fill <= '0;
      end else if (r_fill != FILL_W'(N)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  // Registered copy of the hit, giving the one-cycle-late output used when
  // the detector is built in Moore mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out <= 1'b0;
    end else begin
      r_out <= w_hit;
    end
  end

  // Match counter: one increment per hit, holding at its maximum.
  sat_counter #(
    .W(CNT_W)
  ) u_match_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (w_hit),
    .q    (match_cnt)
  );

  // Select between the combinational and registered match pulse.
  always_comb begin
    out  = (MEALY == MODE_MEALY) ? w_hit : r_out;
    fill = r_fill;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
// Self-checking bench for seq_detect_param. Four instances share one stimulus:
//   dutA : defaults (pattern 1011, overlap on, Mealy)
//   dutB : overlap off
//   dutC : Moore (registered) output
//   dutD : pattern 1111, 2-bit counter, for saturation checks
// -----------------------------------------------------------------------------
module tb_seq_detect_param;
  import seq_detect_pkg::*;

  typedef struct {
    logic       rstn;
    logic       valid;
    logic       bitIn;
    logic       load;
    logic [3:0] pat;
    int         aOut;
    int         aFill;
    int         aCnt;
    int         bOut;
    int         bFill;
    int         bCnt;
    int         cOut;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic       inBit;
  logic       patLoad;
  logic [3:0] patIn;

  logic       aOut, bOut, cOut, dOut;
  logic [7:0] aCnt, bCnt, cCnt;
  logic [1:0] dCnt;
  logic [2:0] aFill, bFill, cFill, dFill;

  int vectorsApplied;
  int checkCount;
  int miscompares;

  vec_t vecs[$];

  seq_detect_param #(.N(4), .PAT_INIT(4'b1011), .OVERLAP(OVL_ON), .MEALY(MODE_MEALY), .CNT_W(8)) dutA (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_bit(inBit), .pat_load(patLoad),
    .pat_in(patIn), .out(aOut), .match_cnt(aCnt), .fill(aFill));

  seq_detect_param #(.N(4), .PAT_INIT(4'b1011), .OVERLAP(OVL_OFF), .MEALY(MODE_MEALY), .CNT_W(8)) dutB (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_bit(inBit), .pat_load(patLoad),
    .pat_in(patIn), .out(bOut), .match_cnt(bCnt), .fill(bFill));

  seq_detect_param #(.N(4), .PAT_INIT(4'b1011), .OVERLAP(OVL_ON), .MEALY(MODE_MOORE), .CNT_W(8)) dutC (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_bit(inBit), .pat_load(patLoad),
    .pat_in(patIn), .out(cOut), .match_cnt(cCnt), .fill(cFill));

  seq_detect_param #(.N(4), .PAT_INIT(4'b1111), .OVERLAP(OVL_ON), .MEALY(MODE_MEALY), .CNT_W(2)) dutD (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_bit(inBit), .pat_load(patLoad),
    .pat_in(patIn), .out(dOut), .match_cnt(dCnt), .fill(dFill));

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rstn, input logic valid, input logic bitIn,
                              input logic load, input logic [3:0] pat,
                              input int aO, input int aF, input int aC,
                              input int bO, input int bF, input int bC, input int cO);
    vec_t v;
    v.rstn = rstn; v.valid = valid; v.bitIn = bitIn; v.load = load; v.pat = pat;
    v.aOut = aO; v.aFill = aF; v.aCnt = aC;
    v.bOut = bO; v.bFill = bF; v.bCnt = bC;
    v.cOut = cO;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and let them settle
  // well before the next rising edge.
  task automatic driveCycle(input logic rstn, input logic valid, input logic bitIn,
                            input logic load, input logic [3:0] pat);
    @(negedge clk);
    reset   = rstn;
    inValid = valid;
    inBit   = bitIn;
    patLoad = load;
    patIn   = pat;
    #2;
  endtask

  task automatic passEdge();
    @(posedge clk);
    #1;
  endtask

  // Outputs are compared before the consuming edge; fill and count after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    driveCycle(v.rstn, v.valid, v.bitIn, v.load, v.pat);
    checkOutput($sformatf("v%0d aOut", idx), int'(aOut), v.aOut);
    checkOutput($sformatf("v%0d bOut", idx), int'(bOut), v.bOut);
    checkOutput($sformatf("v%0d cOut", idx), int'(cOut), v.cOut);
    passEdge();
    checkOutput($sformatf("v%0d aFill", idx), int'(aFill), v.aFill);
    checkOutput($sformatf("v%0d aCnt", idx), int'(aCnt), v.aCnt);
    checkOutput($sformatf("v%0d bFill", idx), int'(bFill), v.bFill);
    checkOutput($sformatf("v%0d bCnt", idx), int'(bCnt), v.bCnt);
    vectorsApplied++;
  endtask

  initial begin
    vectorsApplied = 0;
    checkCount     = 0;
    miscompares    = 0;
    reset   = 1'b0;
    inValid = 1'b0;
    inBit   = 1'b0;
    patLoad = 1'b0;
    patIn   = 4'b0000;

    // rstn valid bit load pat | aOut aFill aCnt | bOut bFill bCnt | cOut
    vecs.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    // Stream 1,0,1,1,0,1,1: overlap hits on bits 4 and 7, non-overlap on 4 only
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 2, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 1, 4, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 4, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 4, 1, 0, 2, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 1, 4, 2, 0, 3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 4, 2, 0, 3, 1, 1));
    // Reset with a valid bit present clears everything
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    // 1,0,1, three idle cycles, then 1
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 2, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0000, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0000, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 1, 4, 1, 1, 0, 1, 0));
    // 1,0,1 then a load together with a valid 1 that would otherwise match
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 4, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 4, 1, 0, 2, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 4, 1, 0, 3, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'b0110, 0, 0, 1, 0, 0, 1, 0));
    // New pattern 0110 matches on the 4th following bit
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 2, 1, 0, 2, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 3, 1, 0, 3, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 4, 2, 1, 0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 4, 2, 0, 0, 2, 1));

    // Initial reset so registered outputs are defined before the table runs
    driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    passEdge();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Saturation on the 2-bit counter: reset restores pattern 1111, then
    // eight 1s give five hits, so the count stops at 3.
    driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    passEdge();
    for (int i = 0; i < 8; i++) begin
      driveCycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      checkOutput($sformatf("sat%0d dOut", i), int'(dOut), (i >= 3) ? 1 : 0);
      passEdge();
      checkOutput($sformatf("sat%0d dCnt", i), int'(dCnt), (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
      checkOutput($sformatf("sat%0d dFill", i), int'(dFill), (i + 1 > 4) ? 4 : i + 1);
      vectorsApplied++;
    end

    // Mid-sequence reset: after 1,0,1 the default-pattern instance would
    // match on a further 1, but reset is asserted on that cycle.
    driveCycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    passEdge();
    driveCycle(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    passEdge();
    driveCycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    passEdge();
    driveCycle(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    checkOutput("rst aOut", int'(aOut), 0);
    checkOutput("rst dOut", int'(dOut), 0);
    passEdge();
    checkOutput("rst aFill", int'(aFill), 0);
    checkOutput("rst aCnt", int'(aCnt), 0);
    checkOutput("rst dFill", int'(dFill), 0);
    checkOutput("rst dCnt", int'(dCnt), 0);
    vectorsApplied++;

    // A lone 1 after reset must not produce any pulse
    driveCycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    checkOutput("lone aOut", int'(aOut), 0);
    checkOutput("lone cOut", int'(cOut), 0);
    checkOutput("lone dOut", int'(dOut), 0);
    passEdge();
    checkOutput("lone aFill", int'(aFill), 1);
    checkOutput("lone aCnt", int'(aCnt), 0);
    checkOutput("lone dCnt", int'(dCnt), 0);
    vectorsApplied++;

    driveCycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("after cOut", int'(cOut), 0);
    passEdge();
    vectorsApplied++;

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
